// File: rtl/aes_pkg.sv
// Shared AES datapath widths, block/state types and the state value
// given to a freshly injected plaintext block.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_STATE_W = 5;

    typedef logic [AES_BLOCK_W-1:0] block_t;
    typedef logic [AES_STATE_W-1:0] state_t;

    localparam state_t ST_INIT = 5'b00001;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr and wraps at N.
// The pointer advances past the winner only when a grant is actually issued.
module aes_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            nxt;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        nxt       = 0;
        ptr_d     = ptr_q;
        for (int i = 0; i < N; i++) begin
            int            c;
            logic [IW-1:0] cidx;
            c = int'(ptr_q) + i;
            if (c >= N) c = c - N;
            cidx = IW'(c);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                grant_idx = cidx;
                nxt       = (c + 1 >= N) ? 0 : c + 1;
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
            ptr_d            = IW'(nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/aes_block_inject_stage.sv
// Round-loop input stage: registers either the recirculating round block or a
// fresh plaintext block popped round-robin from one of NUM_CH input FIFOs.
module aes_block_inject_stage
    import aes_pkg::*;
#(
    parameter  int                 NUM_CH     = 4,
    parameter  int                 BLOCK_W    = AES_BLOCK_W,
    parameter  int                 STATE_W    = AES_STATE_W,
    parameter  logic [STATE_W-1:0] INIT_STATE = STATE_W'(ST_INIT),
    parameter  int                 CNT_W      = 16,
    localparam int                 TAG_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         i_ch_valid,
    input  logic [NUM_CH*BLOCK_W-1:0] i_ch_block,
    output logic [NUM_CH-1:0]         o_ch_pop,
    input  logic                      i_round_valid,
    input  logic                      i_round_retire,
    input  logic [BLOCK_W-1:0]        i_round_block,
    input  logic [STATE_W-1:0]        i_round_state,
    input  logic [TAG_W-1:0]          i_round_tag,
    input  logic                      i_stall,
    output logic                      o_valid,
    output logic [BLOCK_W-1:0]        o_block_out,
    output logic [STATE_W-1:0]        o_state_out,
    output logic [TAG_W-1:0]          o_tag_out,
    output logic                      o_inject,
    output logic [CNT_W-1:0]          o_inject_cnt
);

    logic [BLOCK_W-1:0] ch_blk [NUM_CH];
    logic [NUM_CH-1:0]  grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               slot_free, inject_en;

    logic               valid_q,  valid_d;
    logic [BLOCK_W-1:0] block_q,  block_d;
    logic [STATE_W-1:0] state_q,  state_d;
    logic [TAG_W-1:0]   tag_q,    tag_d;
    logic               inject_q, inject_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_blk[k] = i_ch_block[k*BLOCK_W +: BLOCK_W];
    end

    aes_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (i_ch_valid),
        .en        (inject_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A retiring block frees its slot in the same cycle, so it can be replaced.
    assign slot_free = !i_round_valid || i_round_retire;
    assign inject_en = !i_stall && slot_free && (|i_ch_valid);
    assign o_ch_pop  = rst ? '0 : grant;

    always_comb begin
        valid_d  = valid_q;
        block_d  = block_q;
        state_d  = state_q;
        tag_d    = tag_q;
        inject_d = inject_q;
        cnt_d    = cnt_q;
        if (!i_stall) begin
            if (inject_en) begin
                block_d  = ch_blk[grant_idx];
                state_d  = INIT_STATE;
                tag_d    = grant_idx;
                valid_d  = 1'b1;
                inject_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
            end else if (i_round_valid && !i_round_retire) begin
                block_d  = i_round_block;
                state_d  = i_round_state;
                tag_d    = i_round_tag;
                valid_d  = 1'b1;
                inject_d = 1'b0;
            end else begin
                valid_d  = 1'b0;
                inject_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            block_q  <= '0;
            state_q  <= '0;
            tag_q    <= '0;
            inject_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            block_q  <= block_d;
            state_q  <= state_d;
            tag_q    <= tag_d;
            inject_q <= inject_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_block_out  = block_q;
    assign o_state_out  = state_q;
    assign o_tag_out    = tag_q;
    assign o_inject     = inject_q;
    assign o_inject_cnt = cnt_q;

endmodule

// File: tb/tb_aes_block_inject_stage.sv
// Bench: a 4-channel/16-bit-counter stage and a 3-channel/4-bit-counter stage
// share one stimulus stream and are compared against a behavioural model.
module tb_aes_block_inject_stage;
    import aes_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   ch_valid;
    block_t       chb [4];
    logic [511:0] ch_block;
    logic         round_valid, round_retire, stall;
    block_t       round_block;
    state_t       round_state;
    logic [1:0]   round_tag;

    always_comb ch_block = {chb[3], chb[2], chb[1], chb[0]};

    logic [3:0]  pop_a;
    logic        valid_a, inj_a;
    block_t      block_a;
    state_t      state_a;
    logic [1:0]  tag_a;
    logic [15:0] cnt_a;

    logic [2:0]  pop_b;
    logic        valid_b, inj_b;
    block_t      block_b;
    state_t      state_b;
    logic [1:0]  tag_b;
    logic [3:0]  cnt_b;

    aes_block_inject_stage #(.NUM_CH(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .i_ch_valid(ch_valid), .i_ch_block(ch_block),
        .o_ch_pop(pop_a), .i_round_valid(round_valid), .i_round_retire(round_retire),
        .i_round_block(round_block), .i_round_state(round_state), .i_round_tag(round_tag),
        .i_stall(stall), .o_valid(valid_a), .o_block_out(block_a), .o_state_out(state_a),
        .o_tag_out(tag_a), .o_inject(inj_a), .o_inject_cnt(cnt_a)
    );

    aes_block_inject_stage #(.NUM_CH(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .i_ch_valid(ch_valid[2:0]), .i_ch_block(ch_block[383:0]),
        .o_ch_pop(pop_b), .i_round_valid(round_valid), .i_round_retire(round_retire),
        .i_round_block(round_block), .i_round_state(round_state), .i_round_tag(round_tag),
        .i_stall(stall), .o_valid(valid_b), .o_block_out(block_b), .o_state_out(state_b),
        .o_tag_out(tag_b), .o_inject(inj_b), .o_inject_cnt(cnt_b)
    );

    // Reference state, index 0 = 4-channel stage, index 1 = 3-channel stage.
    int unsigned m_ptr [2];
    logic        m_valid [2];
    block_t      m_block [2];
    state_t      m_state [2];
    logic [1:0]  m_tag [2];
    logic        m_inj [2];
    int unsigned m_cnt [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are set just after a negedge; check pops, advance model, check regs.
    task automatic cycle();
        logic [3:0] exp_pop [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            int          n;
            int          g;
            logic [1:0]  idx;
            n = (d == 0) ? 4 : 3;
            g = -1;
            exp_pop[d] = 4'b0;
            if (rst) begin
                m_valid[d] = 1'b0; m_block[d] = '0; m_state[d] = '0;
                m_tag[d] = '0; m_inj[d] = 1'b0; m_cnt[d] = 0; m_ptr[d] = 0;
            end else if (!stall) begin
                if (!round_valid || round_retire) begin
                    for (int k = 0; k < n; k++) begin
                        idx = 2'((m_ptr[d] + k) % n);
                        if (g < 0 && ch_valid[idx]) g = int'(idx);
                    end
                end
                if (g >= 0) begin
                    idx        = 2'(g);
                    exp_pop[d] = 4'b1 << g;
                    m_block[d] = chb[idx];
                    m_state[d] = 5'b00001;
                    m_tag[d]   = idx;
                    m_valid[d] = 1'b1;
                    m_inj[d]   = 1'b1;
                    m_cnt[d]   = (m_cnt[d] + 1) % ((d == 0) ? 65536 : 16);
                    m_ptr[d]   = (g + 1) % n;
                end else if (round_valid && !round_retire) begin
                    m_block[d] = round_block;
                    m_state[d] = round_state;
                    m_tag[d]   = round_tag;
                    m_valid[d] = 1'b1;
                    m_inj[d]   = 1'b0;
                end else begin
                    m_valid[d] = 1'b0;
                    m_inj[d]   = 1'b0;
                end
            end
        end
        check("pop_a", pop_a, exp_pop[0]);
        check("pop_b", pop_b, exp_pop[1]);
        @(posedge clk);
        #1;
        check("valid_a", valid_a, m_valid[0]);
        check("block_a", block_a, m_block[0]);
        check("state_a", state_a, m_state[0]);
        check("tag_a",   tag_a,   m_tag[0]);
        check("inj_a",   inj_a,   m_inj[0]);
        check("cnt_a",   cnt_a,   m_cnt[0]);
        check("valid_b", valid_b, m_valid[1]);
        check("block_b", block_b, m_block[1]);
        check("state_b", state_b, m_state[1]);
        check("tag_b",   tag_b,   m_tag[1]);
        check("inj_b",   inj_b,   m_inj[1]);
        check("cnt_b",   cnt_b,   m_cnt[1]);
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b0; ch_valid = '0; round_valid = 1'b0; round_retire = 1'b0; stall = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) chb[k] = {$urandom, $urandom, $urandom, $urandom};
        round_block = '0; round_state = '0; round_tag = '0;
        set_idle();
        @(negedge clk);

        // reset then idle
        do_reset();
        cycle();
        check("rst_valid", valid_a, 1'b0);
        check("rst_cnt", cnt_a, 16'd0);
        check("rst_block", block_a, 128'd0);

        // single injection from channel 2
        chb[2] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ch_valid = 4'b0100;
        #1 check("si_pop", pop_a, 4'b0100);
        cycle();
        ch_valid = '0;
        check("si_block", block_a, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("si_state", state_a, 5'b00001);
        check("si_tag", tag_a, 2'd2);
        check("si_inj", inj_a, 1'b1);
        check("si_cnt", cnt_a, 16'd1);

        // round-robin fairness
        do_reset();
        ch_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 check("rr_pop", pop_a, 4'b0001 << (i % 4));
            cycle();
        end
        check("rr_cnt", cnt_a, 16'd5);

        // occupied slot passes through, then retire frees it
        do_reset();
        round_valid = 1'b1; round_retire = 1'b0; round_state = 5'b00111;
        round_tag = 2'd3; round_block = {$urandom, $urandom, $urandom, $urandom};
        ch_valid = 4'b1111;
        #1 check("pt_pop", pop_a, 4'b0000);
        cycle();
        check("pt_state", state_a, 5'b00111);
        check("pt_inj", inj_a, 1'b0);
        round_retire = 1'b1;
        #1 check("ret_pop", pop_a, 4'b0001);
        cycle();
        check("ret_tag", tag_a, 2'd0);
        check("ret_inj", inj_a, 1'b1);
        round_valid = 1'b0; round_retire = 1'b0;

        // stall freezes everything, pointer resumes after release
        do_reset();
        ch_valid = 4'b0001;
        cycle();
        ch_valid = 4'b0011;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("st_pop", pop_a, 4'b0000);
            cycle();
            check("st_block", block_a, chb[0]);
            check("st_cnt", cnt_a, 16'd1);
        end
        stall = 1'b0;
        #1 check("st_rel_pop", pop_a, 4'b0010);
        cycle();
        check("st_rel_tag", tag_a, 2'd1);

        // counter wrap on the 4-bit instance, then mid-operation reset
        do_reset();
        ch_valid = 4'b1111;
        for (int i = 0; i < 16; i++) cycle();
        check("wrap_cnt_b", cnt_b, 4'd0);
        check("wrap_cnt_a", cnt_a, 16'd16);
        check("wrap_valid", valid_a, 1'b1);
        rst = 1'b1;
        #1 check("rst_pop", pop_a, 4'b0000);
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", valid_a, 1'b0);
        #1 check("mid_rst_ptr", pop_a, 4'b0001);
        cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            ch_valid     = 4'($urandom);
            round_valid  = $urandom_range(0, 1) == 1;
            round_retire = $urandom_range(0, 2) == 0;
            round_block  = {$urandom, $urandom, $urandom, $urandom};
            round_state  = 5'($urandom);
            round_tag    = 2'($urandom);
            if ($urandom_range(0, 3) == 0)
                chb[$urandom_range(0, 3)] = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/aes_block_inject_stage.md
Name: aes_block_inject_stage

Overview:
- Registered, multi-channel successor to the combinational data-block selector in the AES iterative round loop.
- Each cycle it either passes the recirculating round block/state through, or injects a fresh plaintext block from one of NUM_CH input FIFOs into a free pipeline slot.
- Injection is round-robin arbitrated and tagged with the source channel.
- Sits between the input FIFOs and the round datapath; its output register feeds the round logic.

Parameters:
- NUM_CH, 4, number of input FIFO channels (1..8)
- BLOCK_W, 128, block width in bits
- STATE_W, 5, round-state width
- INIT_STATE, 5'b00001, state assigned to an injected block
- CNT_W, 16, width of the injected-block counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_ch_valid  in  NUM_CH  per-channel FIFO not-empty
- i_ch_block  in  NUM_CH*BLOCK_W  FIFO head data; channel k at bits [k*BLOCK_W +: BLOCK_W]
- o_ch_pop  out  NUM_CH  one-hot FIFO read strobe, combinational
- i_round_valid  in  1  round slot holds an in-flight block
- i_round_retire  in  1  in-flight block completes this cycle and leaves the loop
- i_round_block  in  BLOCK_W  recirculating block
- i_round_state  in  STATE_W  recirculating state
- i_round_tag  in  $clog2(NUM_CH) (min 1)  recirculating channel tag
- i_stall  in  1  downstream stall; freezes the stage
- o_valid  out  1  output slot occupied
- o_block_out  out  BLOCK_W  registered block
- o_state_out  out  STATE_W  registered state
- o_tag_out  out  tag width  registered channel tag
- o_inject  out  1  registered pulse: this output is a fresh injection
- o_inject_cnt  out  CNT_W  total injections since reset

Behaviour:
- Reset (rst=1 at a clk edge): all registered outputs become 0 (o_valid, o_block_out, o_state_out, o_tag_out, o_inject, o_inject_cnt); rr_ptr becomes 0.
- A reset arriving mid-operation discards any in-flight slot with no pop. o_ch_pop is forced to 0 while rst=1.
- slot_free = !i_round_valid | i_round_retire.
- inject_en = !i_stall & slot_free & (|i_ch_valid).
- Arbitration: search channels starting at rr_ptr, wrapping at NUM_CH. The grant g is the first channel with i_ch_valid set.
  - o_ch_pop = one-hot(g) when inject_en, else 0. This is same-cycle, combinational.
  - On a grant, rr_ptr <= (g+1) mod NUM_CH. Otherwise rr_ptr holds.
- Register update when i_stall=0:
  - On inject: o_block_out <= i_ch_block[g]; o_state_out <= INIT_STATE; o_tag_out <= g; o_valid <= 1; o_inject <= 1; o_inject_cnt <= o_inject_cnt+1, wrapping modulo 2^CNT_W.
  - Otherwise, if i_round_valid & !i_round_retire: pass through round block/state/tag; o_valid <= 1; o_inject <= 0.
  - Otherwise: o_valid <= 0; o_inject <= 0. Block/state/tag hold their last values.
- i_stall=1: all registers hold, including rr_ptr and the counter; no pops. A stall therefore never drops or duplicates a block.
- Latency: one cycle, from input/pop to registered output.
- Retire and inject in the same cycle is legal. The slot is reused and the retiring block is not forwarded.
- Only one injection per cycle.
- With NUM_CH=1 the arbiter degenerates: g=0 and rr_ptr stays 0.

Decomposition:
- Package aes_pkg holds:
  - BLOCK_W and STATE_W default constants
  - typedef block_t (logic [127:0]) and state_t (logic [4:0])
  - constant ST_INIT = 5'b00001
- Natural sub-module: aes_rr_arbiter (parameter N)
  - Inputs: req, en, clk, rst.
  - Outputs: one-hot grant, grant index.
  - Owns rr_ptr.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles, then no valids → all outputs 0, o_ch_pop=0, o_inject_cnt=0.
- Single inject: i_round_valid=0; ch2 valid with block 128'h00112233_44556677_8899AABB_CCDDEEFF → same cycle o_ch_pop=4'b0100; next cycle o_block_out = that block, o_state_out=5'b00001, o_tag_out=2, o_inject=1, o_inject_cnt=1.
- Round-robin fairness: all 4 channels valid continuously, slot always free → pops ch0, ch1, ch2, ch3, ch0 on consecutive cycles; o_inject_cnt=5 after five cycles.
- Occupied slot passthrough: i_round_valid=1, retire=0, state=5'b00111, all channels valid → no pop; next cycle o_state_out=5'b00111, o_inject=0. Then assert retire → ch0 is injected.
- Stall: inject pending on ch1, assert i_stall for 3 cycles → o_ch_pop=0 and outputs frozen throughout; on release, ch1 is popped and rr_ptr continues from its pre-stall value.
- Counter wrap and mid-op reset: CNT_W=4, 16 injections → o_inject_cnt=0. Assert rst while o_valid=1 → next cycle o_valid=0 and rr_ptr=0.
